// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through cache controller for a 16-line
// SRAM array with 4-bit tags and 8-bit data. The controller owns the valid bits.
// The SRAM array itself is external: the controller drives its wordline and
// write port, and reads tag and data back combinationally.
//
// Optional feature macro: CACHE_WRITE_ALLOCATE_EN
//   defined   : every write also writes the line (hit or miss) and marks it valid
//   undefined : a write updates the line only when it hits
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   req_valid/req_ready CPU request handshake; a request is taken on a rising
//                       edge where both are high. req_ready is high only in IDLE
//   req_we/addr/wdata   request kind, address {tag[7:4], index[3:0]}, write data
//   resp_valid          one-cycle response strobe carrying resp_hit / resp_rdata
//                       (resp_rdata is 0 for writes)
//   mem_*               backing memory; mem_req is held until a one-cycle mem_ack,
//                       and mem_rdata is valid in the mem_ack cycle
//   sram_*              SRAM port: one-hot wordline, write enable, write tag and
//                       data; sram_tag_out / sram_data_out are the read values
module cache_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic [7:0]  resp_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        sram_we,
  output logic [15:0] sram_wl,
  output logic [3:0]  sram_tag_in,
  output logic [7:0]  sram_data_in,
  input  logic [3:0]  sram_tag_out,
  input  logic [7:0]  sram_data_out
);

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WMEM, RESP} state_t;

  state_t      state;
  logic [15:0] valid;
  logic        we_q;
  logic [3:0]  tag_q;
  logic [3:0]  idx_q;
  logic [7:0]  wdata_q;
  logic        hit_q;
  logic        hit;
  logic        write_line;

  // The wordline always follows the latched index, so the SRAM read port is
  // already pointing at the right line by the time LOOKUP evaluates the hit.
  assign sram_wl = 16'h0001 << idx_q;
  assign hit     = valid[idx_q] && (sram_tag_out == tag_q);

`ifdef CACHE_WRITE_ALLOCATE_EN
  assign write_line = 1'b1;
`else
  assign write_line = hit;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      valid        <= '0;
      we_q         <= 1'b0;
      tag_q        <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      hit_q        <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_rdata   <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      sram_we      <= 1'b0;
      sram_tag_in  <= '0;
      sram_data_in <= '0;
    end else begin
      // SRAM write and response strobes are single-cycle pulses.
      sram_we    <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            tag_q     <= req_addr[7:4];
            idx_q     <= req_addr[3:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q <= hit;
          if (!we_q) begin
            if (hit) begin
              resp_valid <= 1'b1;
              resp_hit   <= 1'b1;
              resp_rdata <= sram_data_out;
              state      <= RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= {tag_q, idx_q};
              mem_wdata <= '0;
              state     <= FILL;
            end
          end else begin
            // The SRAM write lands at the end of the first WMEM cycle.
            if (write_line) begin
              sram_we       <= 1'b1;
              sram_tag_in   <= tag_q;
              sram_data_in  <= wdata_q;
              valid[idx_q]  <= 1'b1;
            end
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {tag_q, idx_q};
            mem_wdata <= wdata_q;
            state     <= WMEM;
          end
        end
        FILL: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            sram_we      <= 1'b1;
            sram_tag_in  <= tag_q;
            sram_data_in <= mem_rdata;
            valid[idx_q] <= 1'b1;
            resp_valid   <= 1'b1;
            resp_hit     <= 1'b0;
            resp_rdata   <= mem_rdata;
            state        <= RESP;
          end
        end
        WMEM: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b1;
            resp_hit   <= hit_q;
            resp_rdata <= '0;
            state      <= RESP;
          end
        end
        RESP: begin
          resp_hit   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: external SRAM array and backing-memory responder,
// a transaction-level cache model that predicts each response, one compare
// process checking the DUT every cycle, and directed scenarios with literal
// expectations.
module tb_cache_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic        resp_hit;
  logic [7:0]  resp_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        sram_we;
  logic [15:0] sram_wl;
  logic [3:0]  sram_tag_in;
  logic [7:0]  sram_data_in;
  logic [3:0]  sram_tag_out;
  logic [7:0]  sram_data_out;

  cache_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .sram_we(sram_we), .sram_wl(sram_wl), .sram_tag_in(sram_tag_in),
    .sram_data_in(sram_data_in), .sram_tag_out(sram_tag_out),
    .sram_data_out(sram_data_out)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- external SRAM array ----------------
  logic [3:0] s_tag[16]  = '{default: 4'h0};
  logic [7:0] s_data[16] = '{default: 8'h00};

  always_comb begin
    sram_tag_out  = '0;
    sram_data_out = '0;
    for (int i = 0; i < 16; i++)
      if (sram_wl[i]) begin
        sram_tag_out  = s_tag[i];
        sram_data_out = s_data[i];
      end
  end

  always @(posedge clk)
    if (sram_we)
      for (int i = 0; i < 16; i++)
        if (sram_wl[i]) begin
          s_tag[i]  <= sram_tag_in;
          s_data[i] <= sram_data_in;
        end

  // ---------------- backing memory responder ----------------
  logic [7:0] mem_model[256];
  int ack_delay = 2;
  int wait_cnt  = 0;
  bit ack_hold  = 0;
  int spur_req  = 0;
  int spur_done = 0;

  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (spur_req != spur_done) begin
      mem_ack   = 1'b1;
      mem_rdata = 8'hFF;
      spur_done++;
    end else if (mem_req && !ack_hold && !reset) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_we ? 8'h00 : mem_model[mem_addr];
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---------------- model + scoreboard (single compare process) ----------------
  logic [8:0]  exp_q[$];          // {hit, rdata} per accepted request
  logic [15:0] m_valid;
  logic [3:0]  m_tag[16];
  logic [7:0]  m_data[16];
  bit          pending    = 0;
  bit          exp_mem_v  = 0;
  logic        exp_mem_we;
  logic [7:0]  exp_mem_addr;
  logic [7:0]  exp_mem_wdata;
  bit          exp_fast   = 0;
  int          req_cyc    = 0;
  int          txn_memcyc = 0;
  int          n_resp     = 0;
  logic        last_hit;
  logic [7:0]  last_rdata;
  int          last_lat;
  int          last_memcyc;

  initial begin : monitor
    logic [8:0] e;
    logic [3:0] idx;
    logic [3:0] tag;
    logic       mhit;
    bit         alloc;
`ifdef CACHE_WRITE_ALLOCATE_EN
    alloc = 1;
`else
    alloc = 0;
`endif
    for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'h5A;
    mem_model[8'h35] = 8'hA7;
    m_valid = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending   = 0;
        exp_mem_v = 0;
        exp_q.delete();
        m_valid   = '0;
      end else begin
        chk("wl_onehot", 16'($countones(sram_wl)), 16'd1);
        chk("req_ready", req_ready, !pending);
        if (mem_req) begin
          txn_memcyc++;
          if (!exp_mem_v) fail("mem_req_unexpected");
          else begin
            chk("mem_we", mem_we, exp_mem_we);
            chk("mem_addr", mem_addr, exp_mem_addr);
            if (exp_mem_we) chk("mem_wdata", mem_wdata, exp_mem_wdata);
          end
          if (mem_ack) exp_mem_v = 0;
        end
        if (resp_valid) begin
          n_resp++;
          if (exp_q.size() == 0) fail("resp_unexpected");
          else begin
            e = exp_q.pop_front();
            chk("resp_hit", resp_hit, e[8]);
            chk("resp_rdata", resp_rdata, e[7:0]);
          end
          if (exp_mem_v) fail("mem_access_missing");
          if (exp_fast) chk("hit_latency", 16'(cyc - req_cyc), 16'd2);
          last_hit    = resp_hit;
          last_rdata  = resp_rdata;
          last_lat    = cyc - req_cyc;
          last_memcyc = txn_memcyc;
          pending     = 0;
        end
        if (req_valid && req_ready) begin
          idx  = req_addr[3:0];
          tag  = req_addr[7:4];
          mhit = m_valid[idx] && (m_tag[idx] == tag);
          exp_fast = 0;
          if (!req_we) begin
            if (mhit) begin
              exp_q.push_back({1'b1, m_data[idx]});
              exp_fast = 1;
            end else begin
              exp_q.push_back({1'b0, mem_model[req_addr]});
              exp_mem_v = 1; exp_mem_we = 0; exp_mem_addr = req_addr;
              m_valid[idx] = 1'b1; m_tag[idx] = tag; m_data[idx] = mem_model[req_addr];
            end
          end else begin
            exp_q.push_back({mhit, 8'h00});
            exp_mem_v = 1; exp_mem_we = 1; exp_mem_addr = req_addr; exp_mem_wdata = req_wdata;
            mem_model[req_addr] = req_wdata;
            if (alloc || mhit) begin
              m_valid[idx] = 1'b1; m_tag[idx] = tag; m_data[idx] = req_wdata;
            end
          end
          pending    = 1;
          req_cyc    = cyc;
          txn_memcyc = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        input int delay, input bit keep);
    int n0;
    int budget;
    ack_delay = delay;
    budget = 0;
    while (!req_ready && budget < 50) begin @(posedge clk); #1; budget++; end
    if (!req_ready) fail("ready_timeout");
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    n0 = n_resp;
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
    budget = 0;
    while (n_resp == n0 && budget < 100) begin @(posedge clk); #1; budget++; end
    if (n_resp == n0) fail("resp_timeout");
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_ready"}, req_ready, 1'b1);
    chk({tagname, "_resp_valid"}, resp_valid, 1'b0);
    chk({tagname, "_resp_hit"}, resp_hit, 1'b0);
    chk({tagname, "_resp_rdata"}, resp_rdata, 8'h00);
    chk({tagname, "_mem_req"}, mem_req, 1'b0);
    chk({tagname, "_mem_we"}, mem_we, 1'b0);
    chk({tagname, "_mem_addr"}, mem_addr, 8'h00);
    chk({tagname, "_mem_wdata"}, mem_wdata, 8'h00);
    chk({tagname, "_sram_we"}, sram_we, 1'b0);
    chk({tagname, "_sram_wl"}, sram_wl, 16'h0001);
    chk({tagname, "_sram_tag_in"}, sram_tag_in, 4'h0);
    chk({tagname, "_sram_data_in"}, sram_data_in, 8'h00);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int budget;
    logic exp_wa_hit;
`ifdef CACHE_WRITE_ALLOCATE_EN
    exp_wa_hit = 1'b1;
`else
    exp_wa_hit = 1'b0;
`endif
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst_during");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("rst_after");

    // cold read miss, memory answers 0xA7
    do_req(1'b0, 8'h35, 8'h00, 3, 1'b0);
    chk("rd35_cold_hit", last_hit, 1'b0);
    chk("rd35_cold_data", last_rdata, 8'hA7);
    chk("rd35_cold_memcyc", 16'(last_memcyc), 16'd4);
    chk("rd35_cold_lat", 16'(last_lat), 16'd6);

    // same address again: hit, two cycles, no memory traffic
    do_req(1'b0, 8'h35, 8'h00, 3, 1'b0);
    chk("rd35_warm_hit", last_hit, 1'b1);
    chk("rd35_warm_data", last_rdata, 8'hA7);
    chk("rd35_warm_lat", 16'(last_lat), 16'd2);
    chk("rd35_warm_memcyc", 16'(last_memcyc), 16'd0);

    // conflicting tag on the same index evicts the line
    do_req(1'b0, 8'h45, 8'h00, 1, 1'b0);
    chk("rd45_hit", last_hit, 1'b0);
    chk("rd45_data", last_rdata, 8'h1F);
    do_req(1'b0, 8'h35, 8'h00, 0, 1'b0);
    chk("rd35_evicted_hit", last_hit, 1'b0);
    chk("rd35_evicted_data", last_rdata, 8'hA7);

    // write-through miss, then read back
    do_req(1'b1, 8'h9C, 8'h5E, 2, 1'b0);
    chk("wr9c_hit", last_hit, 1'b0);
    chk("wr9c_rdata", last_rdata, 8'h00);
    do_req(1'b0, 8'h9C, 8'h00, 2, 1'b0);
    chk("rd9c_hit", last_hit, exp_wa_hit);
    chk("rd9c_data", last_rdata, 8'h5E);

    // stray mem_ack while idle is ignored
    spur_req++;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_ready", req_ready, 1'b1);
    chk("spur_resp_valid", resp_valid, 1'b0);
    chk("spur_mem_req", mem_req, 1'b0);

    // reset in the middle of a fill
    ack_hold  = 1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h77; req_wdata = 8'h00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    budget = 0;
    while (!mem_req && budget < 20) begin @(posedge clk); #1; budget++; end
    chk("fill_mem_req_seen", mem_req, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_fill_mem_req", mem_req, 1'b0);
    chk("rst_fill_ready", req_ready, 1'b1);
    chk("rst_fill_wl", sram_wl, 16'h0001);
    reset = 1'b0;
    ack_hold = 0;
    @(posedge clk); #1;
    do_req(1'b0, 8'h35, 8'h00, 1, 1'b0);
    chk("rd35_postrst_hit", last_hit, 1'b0);
    chk("rd35_postrst_data", last_rdata, 8'hA7);

    // back-to-back with req_valid held high
    do_req(1'b0, 8'h35, 8'h00, 1, 1'b1);
    chk("b2b_rd35_hit", last_hit, 1'b1);
    do_req(1'b1, 8'h12, 8'h34, 2, 1'b1);
    chk("b2b_wr12_hit", last_hit, 1'b0);
    do_req(1'b0, 8'h12, 8'h00, 2, 1'b1);
    chk("b2b_rd12_hit", last_hit, exp_wa_hit);
    chk("b2b_rd12_data", last_rdata, 8'h34);
    do_req(1'b1, 8'h12, 8'h77, 1, 1'b1);
    chk("b2b_wr12b_hit", last_hit, 1'b1);
    do_req(1'b0, 8'hA5, 8'h00, 0, 1'b0);
    chk("b2b_rda5_hit", last_hit, 1'b0);
    chk("b2b_rda5_data", last_rdata, 8'hFF);
    do_req(1'b0, 8'h12, 8'h00, 0, 1'b0);
    chk("rd12_final_hit", last_hit, 1'b1);
    chk("rd12_final_data", last_rdata, 8'h77);

    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) fail("exp_q_not_drained");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
